// File: rtl/multipli_param.sv
// multipli_param: iterative shift-add multiplier, signed/unsigned per op. Optional MULTIPLI_ACC_EN adds ACC/OVF.
// Latency: START accepted at edge k, S/END_MULT update at edge k+TAM, back in IDLE at k+TAM+1.
// Backpressure: START is ignored while BUSY=1; the next op can be accepted at edge k+TAM+2.
module multipli_param #(
  parameter int TAM = 8
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic               START,
  input  logic               SIGNED,
  input  logic [TAM-1:0]     A,
  input  logic [TAM-1:0]     B,
`ifdef MULTIPLI_ACC_EN
  input  logic               ACC,
  output logic               OVF,
`endif
  output logic [2*TAM-1:0]   S,
  output logic               BUSY,
  output logic               END_MULT
);

  localparam int W  = 2 * TAM;
  localparam int CW = $clog2(TAM);
  localparam logic [CW-1:0] LAST = CW'(TAM - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    mcand_q, mcand_d;   // multiplicand, pre-extended to product width
  logic [TAM-1:0]  mplr_q, mplr_d;
  logic            sgn_q, sgn_d;
  logic [W-1:0]    acc_q, acc_d;       // partial product, never visible on S
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    s_q, s_d;
  logic            busy_q, busy_d;
  logic            end_q, end_d;
  logic [W-1:0]    addend;
  logic [W-1:0]    step_sum;
  logic [W-1:0]    base;
  logic [W-1:0]    final_sum;
`ifdef MULTIPLI_ACC_EN
  logic            acc_en_q, acc_en_d;
  logic            ovf_q, ovf_d;
  logic [W:0]      wide_sum;
`endif

  // Next-state: one multiplier bit per CALC cycle; MSB carries negative weight in signed mode
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplr_d   = mplr_q;
    sgn_d    = sgn_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    s_d      = s_q;
    busy_d   = busy_q;
    end_d    = end_q;
    addend   = mcand_q << cnt_q;
    step_sum = acc_q;
    if (mplr_q[cnt_q]) begin
      if (sgn_q && (cnt_q == LAST)) step_sum = acc_q - addend;
      else                          step_sum = acc_q + addend;
    end
    // Accumulate mode folds the old S in at the end; equivalent to seeding the accumulator with it
    base = '0;
`ifdef MULTIPLI_ACC_EN
    acc_en_d = acc_en_q;
    ovf_d    = ovf_q;
    if (acc_en_q) base = s_q;
    wide_sum = {1'b0, base} + {1'b0, step_sum};
`endif
    final_sum = base + step_sum;

    case (state_q)
      IDLE: begin
        end_d  = 1'b0;
        busy_d = 1'b0;
        if (START) begin
          mcand_d = SIGNED ? {{TAM{A[TAM-1]}}, A} : {{TAM{1'b0}}, A};
          mplr_d  = B;
          sgn_d   = SIGNED;
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CALC;
`ifdef MULTIPLI_ACC_EN
          acc_en_d = ACC;
`endif
        end
      end
      CALC: begin
        acc_d = step_sum;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          s_d     = final_sum;
          end_d   = 1'b1;
          state_d = DONE;
`ifdef MULTIPLI_ACC_EN
          // The product itself never overflows; only the S_old + product addition can
          if (sgn_q)
            ovf_d = (base[W-1] == step_sum[W-1]) && (final_sum[W-1] != base[W-1]);
          else
            ovf_d = wide_sum[W];
`endif
        end
      end
      DONE: begin
        end_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        end_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous reset that aborts any running operation
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplr_q   <= '0;
      sgn_q    <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      s_q      <= '0;
      busy_q   <= 1'b0;
      end_q    <= 1'b0;
`ifdef MULTIPLI_ACC_EN
      acc_en_q <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplr_q   <= mplr_d;
      sgn_q    <= sgn_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      s_q      <= s_d;
      busy_q   <= busy_d;
      end_q    <= end_d;
`ifdef MULTIPLI_ACC_EN
      acc_en_q <= acc_en_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign S        = s_q;
  assign BUSY     = busy_q;
  assign END_MULT = end_q;
`ifdef MULTIPLI_ACC_EN
  assign OVF      = ovf_q;
`endif

endmodule

// File: doc/multipli_param.md
Name: multipli_param

Overview:
- Parametrised iterative multiplier, successor to the fixed signed sequential multiplier. Adds a per-operation signed/unsigned mode, a BUSY indication and a held result register.
- Uses one shift-add step per clock and TAM steps per product.
- Used wherever the datapath needs an area-cheap multiplier with a START/END_MULT handshake.

Parameters:
- TAM, 8, operand width in bits; legal values are TAM >= 2. Product width is 2*TAM.

Ports:
- CLOCK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  synchronous reset, active-high.
- START  in  1  operation request; sampled only in IDLE.
- SIGNED  in  1  mode; 1 = two's-complement operands, 0 = unsigned. Latched with the operands.
- A  in  TAM  multiplicand; latched on the accepted START.
- B  in  TAM  multiplier; latched on the accepted START.
- S  out  2*TAM  product register; held until the next result is written.
- BUSY  out  1  high from acceptance through the DONE cycle.
- END_MULT  out  1  one-cycle pulse; S is valid while it is high.

Behaviour:
- Reset: RESET=1 at a clock edge gives state=IDLE, S=0, BUSY=0, END_MULT=0, and clears the internal accumulator and counter. Reset overrides everything, including a running operation; no END_MULT is produced for the aborted operation.
- States: IDLE, CALC, DONE. All outputs are registered.
- IDLE:
  - START=1 at edge k: latch A, B and SIGNED, clear the partial accumulator, set counter=0, go to CALC. BUSY=1 from edge k.
  - START=0: stay in IDLE.
- CALC:
  - Each edge processes multiplier bit i = counter, LSB first.
  - For i < TAM-1: add A·2^i to the partial sum when bit i = 1.
  - For i = TAM-1: add A·2^i, except in signed mode, where A·2^(TAM-1) is subtracted instead (two's-complement MSB weight).
  - The multiplicand is sign-extended to 2*TAM when SIGNED=1 and zero-extended when SIGNED=0. All arithmetic is modulo 2^(2*TAM).
  - After step TAM-1 (edge k+TAM), write the sum to S and go to DONE.
- DONE: END_MULT=1 and BUSY=1 for exactly one cycle, then return to IDLE, where BUSY=0 and END_MULT=0.
- Latency: START accepted at edge k; S and END_MULT update at edge k+TAM. The next START can be accepted at edge k+TAM+2 at the earliest.
- START while BUSY=1 (CALC or DONE) is ignored. The A, B and SIGNED inputs may change freely after acceptance with no effect.
- S never shows partial sums; it changes only at the DONE transition or on reset.
- The result must equal the exact product in all cases, including the extremes:
  - signed: (-2^(TAM-1))·(-2^(TAM-1)) = 2^(2*TAM-2);
  - unsigned: (2^TAM-1)^2.
- START held high continuously restarts an operation on every IDLE visit, i.e. one operation per TAM+2 cycles.

Optional Feature:
- Macro: MULTIPLI_ACC_EN.
- Defined:
  - Adds input port ACC (1 bit), latched with START, and output OVF (1 bit, reset 0).
  - When ACC=1, the partial accumulator is initialised to the current S instead of 0, so S_new = S_old + A·B modulo 2^(2*TAM).
  - OVF is updated at the DONE transition. It is set on signed overflow (SIGNED=1) or unsigned carry-out (SIGNED=0) of that final sum, and cleared otherwise.
  - ACC=0 behaves exactly as without the macro, with OVF=0.
- Undefined: no ACC or OVF ports; the accumulator always starts at 0.

Test Plan (TAM=8):
- Reset for 3 cycles, then SIGNED=1, A=-128, B=-128, START pulse -> END_MULT exactly 8 edges after acceptance, S=16384, BUSY low the cycle after END_MULT.
- SIGNED=0, A=255, B=255 -> S=65025. Then SIGNED=1 with the same bit patterns (-1·-1) -> S=1.
- SIGNED=1, A=-1, B=2 -> S=16'hFFFE (-2). SIGNED=0, A=255, B=2 -> S=510. Also sweep random signed/unsigned pairs against a reference model.
- Start A=3, B=5. Pulse START again with A=100 at cycle 3 of CALC -> ignored; S=15, exactly one END_MULT pulse.
- Start A=105, B=-71; assert RESET at cycle 4 of CALC -> next edge S=0, BUSY=0, no END_MULT. A new operation 10·12 after release -> S=120.
- With MULTIPLI_ACC_EN defined:
  - 3·5 with ACC=0, then 10·12 with ACC=1 -> S=135, OVF=0.
  - Unsigned 255·255 followed by 255·255 with ACC=1 -> S=64514, OVF=1.
